init_master_8251: RTL and testbench
===================================

INIT_MASTER_8251 -- requirements
Module: init_master_8251

Interface
REQ-001 SHALL have parameter STROBE_CYCLES, default 10, meaning the cycles each bus access holds its enable/strobe asserted (legal 1..255).
REQ-002 SHALL have parameter GAP_CYCLES, default 10, meaning the idle cycles after each access (legal 1..255).
REQ-003 SHALL have parameter POLL_LIMIT, default 255, meaning the maximum status reads per TX byte before timeout (legal 1..255).
REQ-004 I_CLK  input  1  single clock; all state changes on its rising edge.
REQ-005 I_RST  input  1  reset, asynchronous, active-high.
REQ-006 I_START  input  1  one-cycle pulse; begins the init sequence.
REQ-007 I_MODE  input  8  mode byte, sampled when a START is accepted.
REQ-008 I_CMD  input  8  command byte, sampled when a START is accepted.
REQ-009 I_TX_VALID  input  1  a byte is offered for transmission.
REQ-010 I_TX_DATA  input  8  the byte offered for transmission.
REQ-011 O_TX_READY  output  1  a TX byte is accepted when O_TX_READY and I_TX_VALID are both 1.
REQ-012 O_CONTROL_EN  output  1  selects the 8251 control/status port.
REQ-013 O_DATA_EN  output  1  selects the 8251 data port.
REQ-014 O_WE  output  1  write strobe.
REQ-015 O_RD  output  1  read strobe.
REQ-016 O_DATA  output  8  write data; 8'hFF when no write is in progress.
REQ-017 I_DATA  input  8  read data from the 8251 (status byte; bit0 = TxRDY).
REQ-018 O_BUSY  output  1  high while the sequencer is not IDLE or READY.
REQ-019 O_DONE  output  1  high in READY, i.e. the 8251 is programmed.
REQ-020 O_TIMEOUT  output  1  one-cycle pulse when POLL_LIMIT is exhausted.

Function
REQ-021 States SHALL be IDLE, WR_STB, WR_GAP, READY, RD_STB, RD_GAP, TX_STB, TX_GAP.
REQ-022 In IDLE, I_START SHALL latch I_MODE and I_CMD, clear step index to 0, and enter WR_STB on the next cycle; I_START in any other state SHALL be ignored.
REQ-023 Init write sequence (control port) SHALL be exactly: 00, 00, 00, 40, MODE, CMD (step 0..5).
REQ-024 WR_STB SHALL drive O_CONTROL_EN=1, O_WE=1, O_DATA=step byte for exactly STROBE_CYCLES cycles, then go to WR_GAP.
REQ-025 WR_GAP SHALL drive all enables/strobes 0 and O_DATA=8'hFF for exactly GAP_CYCLES cycles, then go to WR_STB with step+1, or to READY after step 5.
REQ-026 In READY, O_TX_READY SHALL be 1; an accepted byte SHALL be latched, the poll counter cleared, and the state SHALL move to RD_STB.
REQ-027 RD_STB SHALL drive O_CONTROL_EN=1, O_RD=1 for STROBE_CYCLES cycles and sample I_DATA on the final strobe cycle, then go to RD_GAP.
REQ-028 After RD_GAP, the state SHALL go to TX_STB if sampled bit0=1; otherwise it SHALL increment the poll counter and return to RD_STB, or, if the counter reaches POLL_LIMIT, pulse O_TIMEOUT, drop the byte, and return to READY.
REQ-029 TX_STB SHALL drive O_DATA_EN=1, O_WE=1, O_DATA=latched byte for STROBE_CYCLES cycles; TX_GAP SHALL then idle GAP_CYCLES cycles and return to READY.
REQ-030 O_CONTROL_EN and O_DATA_EN SHALL never be 1 together; O_WE and O_RD SHALL never be 1 together.
REQ-031 All bus outputs SHALL be registered, with no glitch between consecutive strobe cycles.
REQ-032 O_TX_READY SHALL be 0 in every state except READY; I_TX_VALID outside READY SHALL be ignored and not queued.
REQ-033 The cycle counter SHALL be 8-bit, reload on every state entry, and never wrap.

Reset
REQ-034 While I_RST=1: state IDLE, O_CONTROL_EN=O_DATA_EN=O_WE=O_RD=0, O_DATA=8'hFF, O_TX_READY=O_BUSY=O_DONE=O_TIMEOUT=0, all counters/latches 0.
REQ-035 Reset asserted mid-access SHALL deassert strobes immediately (asynchronously); after release the block SHALL remain IDLE until a new I_START.

Verification
REQ-036 START with MODE=4E, CMD=37, default params -> six control writes 00,00,00,40,4E,37, each 10 strobe + 10 gap cycles; O_DONE=1 exactly 120 cycles after the first strobe.
REQ-037 READY, TX byte 41, I_DATA=05 -> one 10-cycle status read, then a data-port write of 41, then O_TX_READY=1 again after the gap.
REQ-038 I_DATA=04 for 3 reads then 05 -> four status reads, then write; O_TIMEOUT stays 0.
REQ-039 POLL_LIMIT=2, I_DATA=00 -> two reads, O_TIMEOUT one-cycle pulse, no data write, return to READY.
REQ-040 I_RST=1 during the step-3 (40) strobe -> strobes 0 and O_DATA=FF within the same cycle; a second I_START restarts from step 0.
REQ-041 I_START pulsed while BUSY, and I_TX_VALID during init -> both ignored; sequence and bus traffic unchanged.

Source files
------------

// File: rtl/init_master_8251.sv
// Sequencer that programs an 8251 USART (mode/command writes) and then paces TX bytes
// through status polling; all bus outputs are registered from the next-state decode.
module init_master_8251 #(
   parameter int STROBE_CYCLES = 10,
   parameter int GAP_CYCLES    = 10,
   parameter int POLL_LIMIT    = 255
) (
   input  logic       I_CLK,
   input  logic       I_RST,
   input  logic       I_START,
   input  logic [7:0] I_MODE,
   input  logic [7:0] I_CMD,
   input  logic       I_TX_VALID,
   input  logic [7:0] I_TX_DATA,
   output logic       O_TX_READY,
   output logic       O_CONTROL_EN,
   output logic       O_DATA_EN,
   output logic       O_WE,
   output logic       O_RD,
   output logic [7:0] O_DATA,
   input  logic [7:0] I_DATA,
   output logic       O_BUSY,
   output logic       O_DONE,
   output logic       O_TIMEOUT
);

   typedef enum logic [2:0] {
      IDLE, WR_STB, WR_GAP, READY, RD_STB, RD_GAP, TX_STB, TX_GAP
   } state_t;

   localparam logic [7:0] STB_LOAD  = 8'(STROBE_CYCLES - 1);
   localparam logic [7:0] GAP_LOAD  = 8'(GAP_CYCLES - 1);
   localparam logic [8:0] POLL_LIM9 = 9'(POLL_LIMIT);

   state_t     state, state_nxt;
   logic [7:0] cnt, cnt_load;
   logic [2:0] step, step_nxt;
   logic [7:0] mode_q, cmd_q, tx_q, poll_cnt;
   logic       tx_rdy_q;
   logic       last, timeout_nxt, poll_inc;
   logic       ctrl_en_nxt, data_en_nxt, we_nxt, rd_nxt, busy_nxt, done_nxt;
   logic [7:0] data_nxt;

   // Only TxRDY matters; the remaining status bits are deliberately ignored.
   logic unused_status;
   assign unused_status = ^I_DATA[7:1];

   assign last = (cnt == 8'd0);

   function automatic logic [7:0] step_byte(input logic [2:0] s, input logic [7:0] m,
                                            input logic [7:0] c);
      case (s)
         3'd3:    step_byte = 8'h40;
         3'd4:    step_byte = m;
         3'd5:    step_byte = c;
         default: step_byte = 8'h00;
      endcase
   endfunction

   always_comb begin
      state_nxt   = state;
      step_nxt    = step;
      timeout_nxt = 1'b0;
      poll_inc    = 1'b0;
      case (state)
         IDLE:   if (I_START) begin state_nxt = WR_STB; step_nxt = 3'd0; end
         WR_STB: if (last) state_nxt = WR_GAP;
         WR_GAP: if (last) begin
            if (step == 3'd5) state_nxt = READY;
            else begin state_nxt = WR_STB; step_nxt = step + 3'd1; end
         end
         READY:  if (I_TX_VALID) state_nxt = RD_STB;
         RD_STB: if (last) state_nxt = RD_GAP;
         RD_GAP: if (last) begin
            if (tx_rdy_q) state_nxt = TX_STB;
            else if ({1'b0, poll_cnt} + 9'd1 >= POLL_LIM9) begin
               state_nxt   = READY;
               timeout_nxt = 1'b1;
            end else begin
               state_nxt = RD_STB;
               poll_inc  = 1'b1;
            end
         end
         TX_STB: if (last) state_nxt = TX_GAP;
         TX_GAP: if (last) state_nxt = READY;
         default: state_nxt = IDLE;
      endcase
   end

   // Bus outputs come from the state being entered, so they toggle exactly with it.
   always_comb begin
      ctrl_en_nxt = 1'b0;
      data_en_nxt = 1'b0;
      we_nxt      = 1'b0;
      rd_nxt      = 1'b0;
      data_nxt    = 8'hFF;
      cnt_load    = 8'd0;
      case (state_nxt)
         WR_STB: begin
            ctrl_en_nxt = 1'b1;
            we_nxt      = 1'b1;
            data_nxt    = step_byte(step_nxt, mode_q, cmd_q);
            cnt_load    = STB_LOAD;
         end
         RD_STB: begin
            ctrl_en_nxt = 1'b1;
            rd_nxt      = 1'b1;
            cnt_load    = STB_LOAD;
         end
         TX_STB: begin
            data_en_nxt = 1'b1;
            we_nxt      = 1'b1;
            data_nxt    = tx_q;
            cnt_load    = STB_LOAD;
         end
         WR_GAP, RD_GAP, TX_GAP: cnt_load = GAP_LOAD;
         default: cnt_load = 8'd0;
      endcase
      busy_nxt = (state_nxt != IDLE) && (state_nxt != READY);
      done_nxt = (state_nxt == READY);
   end

   always_ff @(posedge I_CLK or posedge I_RST) begin
      if (I_RST) begin
         state    <= IDLE;
         cnt      <= 8'd0;
         step     <= 3'd0;
         mode_q   <= 8'd0;
         cmd_q    <= 8'd0;
         tx_q     <= 8'd0;
         poll_cnt <= 8'd0;
         tx_rdy_q <= 1'b0;
      end else begin
         state <= state_nxt;
         step  <= step_nxt;
         if (state_nxt != state) cnt <= cnt_load;
         else if (cnt != 8'd0)   cnt <= cnt - 8'd1;
         if (state == IDLE && I_START) begin
            mode_q <= I_MODE;
            cmd_q  <= I_CMD;
         end
         if (state == READY && I_TX_VALID) begin
            tx_q     <= I_TX_DATA;
            poll_cnt <= 8'd0;
         end else if (poll_inc) begin
            poll_cnt <= poll_cnt + 8'd1;
         end
         if (state == RD_STB && last) tx_rdy_q <= I_DATA[0];
      end
   end

   always_ff @(posedge I_CLK or posedge I_RST) begin
      if (I_RST) begin
         O_CONTROL_EN <= 1'b0;
         O_DATA_EN    <= 1'b0;
         O_WE         <= 1'b0;
         O_RD         <= 1'b0;
         O_DATA       <= 8'hFF;
         O_TX_READY   <= 1'b0;
         O_BUSY       <= 1'b0;
         O_DONE       <= 1'b0;
         O_TIMEOUT    <= 1'b0;
      end else begin
         O_CONTROL_EN <= ctrl_en_nxt;
         O_DATA_EN    <= data_en_nxt;
         O_WE         <= we_nxt;
         O_RD         <= rd_nxt;
         O_DATA       <= data_nxt;
         O_TX_READY   <= done_nxt;
         O_BUSY       <= busy_nxt;
         O_DONE       <= done_nxt;
         O_TIMEOUT    <= timeout_nxt;
      end
   end

endmodule

// File: tb/tb_init_master_8251.sv
// Bench for init_master_8251: a bus monitor turns strobe runs into accesses and
// checks them against a queue of expected accesses pushed by each scenario task.
module tb_init_master_8251;

   logic       I_CLK = 1'b0;
   logic       I_RST = 1'b1;
   logic       I_START = 1'b0;
   logic [7:0] I_MODE = 8'h00;
   logic [7:0] I_CMD = 8'h00;
   logic       I_TX_VALID = 1'b0;
   logic [7:0] I_TX_DATA = 8'h00;
   logic [7:0] I_DATA = 8'h00;
   logic       O_TX_READY, O_CONTROL_EN, O_DATA_EN, O_WE, O_RD, O_BUSY, O_DONE, O_TIMEOUT;
   logic [7:0] O_DATA;

   init_master_8251 dut (
      .I_CLK(I_CLK), .I_RST(I_RST), .I_START(I_START), .I_MODE(I_MODE), .I_CMD(I_CMD),
      .I_TX_VALID(I_TX_VALID), .I_TX_DATA(I_TX_DATA), .O_TX_READY(O_TX_READY),
      .O_CONTROL_EN(O_CONTROL_EN), .O_DATA_EN(O_DATA_EN), .O_WE(O_WE), .O_RD(O_RD),
      .O_DATA(O_DATA), .I_DATA(I_DATA), .O_BUSY(O_BUSY), .O_DONE(O_DONE),
      .O_TIMEOUT(O_TIMEOUT)
   );

   always #5 I_CLK = ~I_CLK;

   // kind: 0 = control write, 1 = status read, 2 = data write
   typedef struct packed {
      logic [1:0] kind;
      logic [7:0] dat;
      logic [7:0] len;
   } acc_t;

   acc_t exp_q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   logic [1:0] run_kind = 2'd0;
   logic [7:0] run_dat = 8'd0;
   int         run_len = 0;

   always @(negedge I_CLK) begin
      logic [1:0] k;
      logic [7:0] d;
      acc_t       got, want;
      n_checks++;
      if ((O_CONTROL_EN && O_DATA_EN) || (O_WE && O_RD) || (!O_WE && O_DATA !== 8'hFF)) begin
         n_errors++;
         $display("FAIL bus_exclusive: ce=%b de=%b we=%b rd=%b data=%h", O_CONTROL_EN,
                  O_DATA_EN, O_WE, O_RD, O_DATA);
      end
      if (I_RST) begin
         run_len = 0;
      end else begin
         k = O_DATA_EN ? 2'd2 : (O_RD ? 2'd1 : 2'd0);
         d = O_RD ? 8'h00 : O_DATA;
         if ((O_WE || O_RD) && run_len > 0 && k == run_kind && d == run_dat) begin
            run_len++;
         end else begin
            if (run_len > 0) begin
               got = '{kind: run_kind, dat: run_dat, len: 8'(run_len)};
               n_checks++;
               if (exp_q.size() == 0) begin
                  n_errors++;
                  $display("FAIL unexpected_access: got %h, none required", got);
               end else begin
                  want = exp_q.pop_front();
                  if (got !== want) begin
                     n_errors++;
                     $display("FAIL access: got kind/dat/len %0d/%h/%0d required %0d/%h/%0d",
                              got.kind, got.dat, got.len, want.kind, want.dat, want.len);
                  end
               end
            end
            if (O_WE || O_RD) begin
               run_kind = k;
               run_dat  = d;
               run_len  = 1;
            end else begin
               run_len = 0;
            end
         end
      end
   end

   task automatic test_reset();
      I_RST = 1'b1;
      repeat (3) @(negedge I_CLK);
      n_checks++;
      if ({O_CONTROL_EN, O_DATA_EN, O_WE, O_RD} !== 4'b0 || O_DATA !== 8'hFF) begin
         n_errors++;
         $display("FAIL reset_bus: en/we/rd=%b data=%h required 0000/ff",
                  {O_CONTROL_EN, O_DATA_EN, O_WE, O_RD}, O_DATA);
      end
      n_checks++;
      if ({O_TX_READY, O_BUSY, O_DONE, O_TIMEOUT} !== 4'b0) begin
         n_errors++;
         $display("FAIL reset_status: rdy/busy/done/tmo=%b required 0000",
                  {O_TX_READY, O_BUSY, O_DONE, O_TIMEOUT});
      end
      I_RST = 1'b0;
      I_TX_VALID = 1'b1;
      repeat (5) @(negedge I_CLK);
      I_TX_VALID = 1'b0;
      n_checks++;
      if ({O_BUSY, O_WE, O_RD, O_TX_READY} !== 4'b0) begin
         n_errors++;
         $display("FAIL idle_after_reset: busy/we/rd/rdy=%b required 0000",
                  {O_BUSY, O_WE, O_RD, O_TX_READY});
      end
   endtask

   // Also pulses START and offers a TX byte mid-sequence; both must be ignored.
   task automatic test_init(input logic [7:0] m, input logic [7:0] c);
      int t;
      int w;
      exp_q.push_back('{2'd0, 8'h00, 8'd10});
      exp_q.push_back('{2'd0, 8'h00, 8'd10});
      exp_q.push_back('{2'd0, 8'h00, 8'd10});
      exp_q.push_back('{2'd0, 8'h40, 8'd10});
      exp_q.push_back('{2'd0, m, 8'd10});
      exp_q.push_back('{2'd0, c, 8'd10});
      @(negedge I_CLK);
      I_MODE = m; I_CMD = c; I_START = 1'b1;
      @(negedge I_CLK);
      I_START = 1'b0; I_MODE = 8'h00; I_CMD = 8'hAA;
      w = 0;
      while (!O_WE && w < 50) begin @(negedge I_CLK); w++; end
      t = 0;
      while (!O_DONE && t < 500) begin
         @(negedge I_CLK);
         t++;
         if (t == 30) begin I_START = 1'b1; I_MODE = 8'hFF; I_CMD = 8'hFF; end
         if (t == 31) I_START = 1'b0;
         if (t == 40) begin I_TX_VALID = 1'b1; I_TX_DATA = 8'h55; end
         if (t == 60) I_TX_VALID = 1'b0;
      end
      n_checks++;
      if (t != 120 || O_DONE !== 1'b1) begin
         n_errors++;
         $display("FAIL init_done_time: done=%b after %0d cycles required 1 after 120", O_DONE, t);
      end
      n_checks++;
      if (O_TX_READY !== 1'b1 || O_BUSY !== 1'b0) begin
         n_errors++;
         $display("FAIL init_ready: rdy=%b busy=%b required 1/0", O_TX_READY, O_BUSY);
      end
      n_checks++;
      if (exp_q.size() != 0) begin
         n_errors++;
         $display("FAIL init_writes: %0d writes missing, required 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   // One TX byte: status reads fail n_fail times before TxRDY, or never when tmo is set.
   task automatic test_tx(input string name, input logic [7:0] b, input logic [7:0] first_dat,
                          input int n_fail, input int n_reads, input bit tmo);
      int cyc, rd_cnt, tmo_cnt, gap_start;
      bit prev_rd, prev_we;
      for (int i = 0; i < n_reads; i++) exp_q.push_back('{2'd1, 8'h00, 8'd10});
      if (!tmo) exp_q.push_back('{2'd2, b, 8'd10});
      I_DATA = first_dat;
      I_TX_VALID = 1'b1; I_TX_DATA = b;
      @(negedge I_CLK);
      I_TX_VALID = 1'b0; I_TX_DATA = 8'h00;
      n_checks++;
      if (O_TX_READY !== 1'b0 || O_RD !== 1'b1) begin
         n_errors++;
         $display("FAIL %s_accept: rdy=%b rd=%b required 0/1", name, O_TX_READY, O_RD);
      end
      cyc = 0; rd_cnt = 0; tmo_cnt = 0; gap_start = -1;
      prev_rd = O_RD; prev_we = O_WE;
      while (!O_TX_READY && cyc < 8000) begin
         @(negedge I_CLK);
         cyc++;
         if (prev_rd && !O_RD) begin
            rd_cnt++;
            if (rd_cnt == n_fail) I_DATA = 8'h05;
         end
         if (prev_we && !O_WE) gap_start = cyc;
         if (O_TIMEOUT) tmo_cnt++;
         prev_rd = O_RD; prev_we = O_WE;
      end
      n_checks++;
      if (O_TX_READY !== 1'b1) begin
         n_errors++;
         $display("FAIL %s_return: tx_ready=%b after %0d cycles required 1", name, O_TX_READY, cyc);
      end
      @(negedge I_CLK);
      if (O_TIMEOUT) tmo_cnt++;
      n_checks++;
      if (rd_cnt != n_reads) begin
         n_errors++;
         $display("FAIL %s_reads: got %0d required %0d", name, rd_cnt, n_reads);
      end
      n_checks++;
      if (tmo_cnt != (tmo ? 1 : 0)) begin
         n_errors++;
         $display("FAIL %s_timeout_cycles: got %0d required %0d", name, tmo_cnt, tmo ? 1 : 0);
      end
      if (!tmo) begin
         n_checks++;
         if (cyc - gap_start != 10) begin
            n_errors++;
            $display("FAIL %s_gap: ready %0d cycles after write required 10", name, cyc - gap_start);
         end
      end
      n_checks++;
      if (exp_q.size() != 0) begin
         n_errors++;
         $display("FAIL %s_accesses: %0d missing required 0", name, exp_q.size());
         exp_q.delete();
      end
      I_DATA = 8'h00;
   endtask

   task automatic test_reset_mid_access();
      int w;
      I_RST = 1'b1;
      @(negedge I_CLK);
      I_RST = 1'b0;
      exp_q.push_back('{2'd0, 8'h00, 8'd10});
      exp_q.push_back('{2'd0, 8'h00, 8'd10});
      exp_q.push_back('{2'd0, 8'h00, 8'd10});
      @(negedge I_CLK);
      I_MODE = 8'h4E; I_CMD = 8'h37; I_START = 1'b1;
      @(negedge I_CLK);
      I_START = 1'b0;
      w = 0;
      while (!(O_WE && O_DATA == 8'h40) && w < 200) begin @(negedge I_CLK); w++; end
      repeat (3) @(negedge I_CLK);
      #2 I_RST = 1'b1;
      #1;
      n_checks++;
      if ({O_CONTROL_EN, O_WE} !== 2'b00 || O_DATA !== 8'hFF) begin
         n_errors++;
         $display("FAIL async_reset: ce/we=%b data=%h required 00/ff", {O_CONTROL_EN, O_WE}, O_DATA);
      end
      repeat (2) @(negedge I_CLK);
      I_RST = 1'b0;
      repeat (30) @(negedge I_CLK);
      n_checks++;
      if ({O_BUSY, O_WE, O_CONTROL_EN, O_DONE} !== 4'b0) begin
         n_errors++;
         $display("FAIL stay_idle: busy/we/ce/done=%b required 0000",
                  {O_BUSY, O_WE, O_CONTROL_EN, O_DONE});
      end
      n_checks++;
      if (exp_q.size() != 0) begin
         n_errors++;
         $display("FAIL pre_reset_writes: %0d missing required 0", exp_q.size());
         exp_q.delete();
      end
      test_init(8'hCF, 8'h27);
   endtask

   initial begin
      test_reset();
      test_init(8'h4E, 8'h37);
      test_tx("tx_single", 8'h41, 8'h05, 0, 1, 1'b0);
      test_tx("tx_poll", 8'h5A, 8'h04, 3, 4, 1'b0);
      test_tx("tx_timeout", 8'hC3, 8'h00, 100000, 255, 1'b1);
      test_tx("tx_after_tmo", 8'h7E, 8'h05, 0, 1, 1'b0);
      test_reset_mid_access();
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
